// File: rtl/sonic_pkg.sv
// Shared types and default timing for the HC-SR04 trig/echo interface.
// The default constants are used by both the responder and the ranging block.
package sonic_pkg;

  localparam int DIST_W = 9;

  localparam int DEF_TRIG_MIN_CYC = 1000;
  localparam int DEF_BURST_CYC    = 25000;
  localparam int DEF_CYC_PER_CM   = 5800;
  localparam int DEF_MIN_CM       = 2;
  localparam int DEF_MAX_CM       = 400;
  localparam int DEF_NOOBJ_CYC    = 3800000;
  localparam int DEF_HOLDOFF_CYC  = 1000000;

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO,
    HOLDOFF
  } sonic_state_t;

endpackage

// File: rtl/cm_pulse_timer.sv
// Multiplier-free d_cm * CYC_PER_CM timer: a cm-tick prescaler drives a cm down-counter.
// done is a combinational strobe in the last cycle of the interval.
module cm_pulse_timer
  import sonic_pkg::*;
#(
  parameter int CYC_PER_CM = DEF_CYC_PER_CM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DIST_W-1:0] d_cm,
  output logic              done
);

  localparam int PRE_W = $clog2(CYC_PER_CM + 1);

  logic [PRE_W-1:0]  presc;
  logic [DIST_W-1:0] cm_left;
  logic              running;
  logic              tick;

  assign tick = running && (presc == PRE_W'(CYC_PER_CM - 1));
  assign done = tick && (cm_left < DIST_W'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      cm_left <= '0;
      running <= 1'b0;
    end else if (load) begin
      presc   <= '0;
      cm_left <= d_cm;
      running <= 1'b1;
    end else if (running) begin
      if (tick) begin
        presc   <= '0;
        cm_left <= cm_left - DIST_W'(1);
        if (done) running <= 1'b0;
      end else begin
        presc <= presc + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/sonic_echo_responder.sv
// HC-SR04 target model: qualifies a trig pulse, waits the burst time, then
// emits an echo whose width encodes the programmed distance.
module sonic_echo_responder
  import sonic_pkg::*;
#(
  parameter int TRIG_MIN_CYC = DEF_TRIG_MIN_CYC,
  parameter int BURST_CYC    = DEF_BURST_CYC,
  parameter int CYC_PER_CM   = DEF_CYC_PER_CM,
  parameter int MIN_CM       = DEF_MIN_CM,
  parameter int MAX_CM       = DEF_MAX_CM,
  parameter int NOOBJ_CYC    = DEF_NOOBJ_CYC,
  parameter int HOLDOFF_CYC  = DEF_HOLDOFF_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [DIST_W-1:0] distance_cm,
  output logic              echo,
  output logic              busy,
  output logic              trig_err,
  output logic [15:0]       meas_cnt
);

  localparam int CNT_W = $clog2(NOOBJ_CYC + HOLDOFF_CYC + BURST_CYC + TRIG_MIN_CYC + 2);

  logic trig_s1, trig_s2, trig_d;
  logic trig_rise, trig_fall;

  sonic_state_t      state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [DIST_W-1:0] dist_q, dist_next;
  logic [DIST_W-1:0] clamped_d;
  logic              noobj;
  logic              echo_next, err_next, meas_inc;
  logic              timer_load, timer_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_d  <= 1'b0;
    end else begin
      trig_s1 <= trig;
      trig_s2 <= trig_s1;
      trig_d  <= trig_s2;
    end
  end

  assign trig_rise = trig_s2 & ~trig_d;
  assign trig_fall = ~trig_s2 & trig_d;

  assign noobj     = dist_q > DIST_W'(MAX_CM);
  assign clamped_d = (dist_q < DIST_W'(MIN_CM)) ? DIST_W'(MIN_CM) : dist_q;
  assign busy      = (state != IDLE);

  cm_pulse_timer #(
    .CYC_PER_CM(CYC_PER_CM)
  ) u_cm_timer (
    .clk (clk),
    .rst (rst),
    .load(timer_load),
    .d_cm(clamped_d),
    .done(timer_done)
  );

  // The width counter starts at 1 so it holds the exact number of high cycles
  // at the fall. BURST runs one extra cycle to absorb the edge-detect stage,
  // giving a fixed 3+BURST_CYC latency from the first low sample of trig.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    dist_next  = dist_q;
    echo_next  = 1'b0;
    err_next   = 1'b0;
    meas_inc   = 1'b0;
    timer_load = 1'b0;
    case (state)
      IDLE: begin
        if (trig_rise) begin
          state_next = TRIG_HI;
          cnt_next   = CNT_W'(1);
        end
      end
      TRIG_HI: begin
        if (trig_fall) begin
          cnt_next = '0;
          if (cnt >= CNT_W'(TRIG_MIN_CYC)) begin
            state_next = BURST;
            dist_next  = distance_cm;
          end else begin
            state_next = IDLE;
            err_next   = 1'b1;
          end
        end else if (cnt < CNT_W'(TRIG_MIN_CYC)) begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      BURST: begin
        if (cnt == CNT_W'(BURST_CYC)) begin
          state_next = ECHO;
          cnt_next   = '0;
          timer_load = ~noobj;
          echo_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ECHO: begin
        echo_next = 1'b1;
        if (noobj ? (cnt == CNT_W'(NOOBJ_CYC - 1)) : timer_done) begin
          state_next = HOLDOFF;
          cnt_next   = '0;
          echo_next  = 1'b0;
          meas_inc   = 1'b1;
        end else if (noobj) begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (cnt == CNT_W'(HOLDOFF_CYC - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dist_q   <= '0;
      echo     <= 1'b0;
      trig_err <= 1'b0;
      meas_cnt <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      dist_q   <= dist_next;
      echo     <= echo_next;
      trig_err <= err_next;
      if (meas_inc) meas_cnt <= meas_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sonic_echo_responder.sv
// Scoreboard bench for sonic_echo_responder using small timing parameters.
// Stimulus pushes expected echo/trig_err events; a negedge monitor pops and checks them.
module tb_sonic_echo_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0;
  logic [8:0]  distance_cm = '0;
  logic        echo, busy, trig_err;
  logic [15:0] meas_cnt;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int meas_model = 0;

  typedef struct {
    bit is_err;
    int rise;
    int width;
    int meas;
  } exp_t;

  exp_t sb[$];

  sonic_echo_responder #(
    .TRIG_MIN_CYC(10),
    .BURST_CYC   (20),
    .CYC_PER_CM  (4),
    .MIN_CM      (2),
    .MAX_CM      (400),
    .NOOBJ_CYC   (2000),
    .HOLDOFF_CYC (50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig),
    .distance_cm(distance_cm),
    .echo       (echo),
    .busy       (busy),
    .trig_err   (trig_err),
    .meas_cnt   (meas_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Echo is expected high first at posedge (fall negedge cycle + 1) + 3 + 20.
  task automatic applyStimulus(input int d, input int high, input int exp_width,
                               input bit is_err, input bit aborted, output int rise_at);
    exp_t e;
    @(negedge clk);
    distance_cm = 9'(d);
    trig = 1'b1;
    repeat (high) @(negedge clk);
    checkOutput("busy_trig_hi", int'(busy), 1);
    trig = 1'b0;
    rise_at = cyc + 24;
    if (!is_err) meas_model = aborted ? 0 : ((meas_model + 1) & 16'hFFFF);
    e.is_err = is_err;
    e.rise   = rise_at;
    e.width  = exp_width;
    e.meas   = meas_model;
    sb.push_back(e);
  endtask

  task automatic pulseTrig(input int high);
    trig = 1'b1;
    repeat (high) @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic waitIdle(input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", int'(busy), 0);
  endtask

  bit echo_prev = 1'b0;
  bit err_prev = 1'b0;
  int rise_seen = 0;

  always @(negedge clk) begin
    exp_t e;
    if (echo && !echo_prev) rise_seen = cyc;
    if (!echo && echo_prev) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_echo", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("echo_kind", 0, int'(e.is_err));
        checkOutput("echo_latency", rise_seen, e.rise);
        checkOutput("echo_width", cyc - rise_seen, e.width);
        checkOutput("meas_cnt", int'(meas_cnt), e.meas);
      end
    end
    if (trig_err) begin
      checkOutput("trig_err_len", int'(err_prev), 0);
      if (!err_prev) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_trig_err", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("err_kind", 1, int'(e.is_err));
        end
      end
    end
    echo_prev = echo;
    err_prev  = trig_err;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_echo", int'(echo), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_trig_err", int'(trig_err), 0);
    checkOutput("reset_meas_cnt", int'(meas_cnt), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] nominal 30 cm");
    applyStimulus(30, 12, 120, 1'b0, 1'b0, r);
    waitIdle(3000);

    $display("[TB] short trigger");
    applyStimulus(30, 5, 0, 1'b1, 1'b0, r);
    repeat (8) @(negedge clk);
    checkOutput("busy_after_short", int'(busy), 0);
    checkOutput("meas_after_short", int'(meas_cnt), 1);

    $display("[TB] clamp and range");
    applyStimulus(0, 12, 8, 1'b0, 1'b0, r);
    waitIdle(3000);
    applyStimulus(400, 12, 1600, 1'b0, 1'b0, r);
    waitIdle(3000);
    applyStimulus(401, 12, 2000, 1'b0, 1'b0, r);
    waitIdle(3000);

    $display("[TB] retrigger and distance latch");
    applyStimulus(30, 12, 120, 1'b0, 1'b0, r);
    waitUntil(r + 10);
    pulseTrig(12);
    waitUntil(r + 40);
    distance_cm = 9'd60;
    waitUntil(r + 130);
    pulseTrig(12);
    waitIdle(3000);
    applyStimulus(60, 12, 240, 1'b0, 1'b0, r);
    waitIdle(3000);

    $display("[TB] reset mid-echo");
    applyStimulus(30, 12, 50, 1'b0, 1'b1, r);
    waitUntil(r + 49);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_echo", int'(echo), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_meas_cnt", int'(meas_cnt), 0);
    repeat (3) @(negedge clk);
    applyStimulus(30, 12, 120, 1'b0, 1'b0, r);
    waitIdle(3000);

    $display("[TB] meas_cnt wrap");
    force dut.meas_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.meas_cnt;
    meas_model = 16'hFFFF;
    applyStimulus(30, 12, 120, 1'b0, 1'b0, r);
    waitIdle(3000);

    repeat (5) @(negedge clk);
    checkOutput("pending_events", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
